univ_shiftreg: RTL and testbench

UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

---
 rtl/univ_shiftreg_pkg.sv | 25 ++
 rtl/shreg_burst_ctl.sv | 54 +++++
 rtl/univ_shiftreg.sv | 114 +++++++++++
 tb/tb_univ_shiftreg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/univ_shiftreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shiftreg_pkg
//  Description : Opcode constants and decode helper for the universal
//                shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
package univ_shiftreg_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SAR  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ROL  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // Only shift/rotate opcodes can be repeated as a burst.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHR) && (op <= OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shreg_burst_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_burst_ctl
//  Description : Burst down-counter producing busy and a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module shreg_burst_ctl #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= c_ZERO;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (r_busy) begin
            // The edge that performs the last shift also ends the burst.
            r_done <= (r_cnt == c_ONE);
            r_busy <= (r_cnt != c_ONE);
            if (r_cnt != c_ZERO) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end else if (i_start) begin
            if (i_count == c_ZERO) begin
                r_done <= 1'b1;
            end else begin
                r_busy <= 1'b1;
                r_cnt  <= i_count;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/univ_shiftreg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shiftreg
//  Description : Universal shift register with single-step ops and counted
//                shift/rotate bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shiftreg
    import univ_shiftreg_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             din,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             sout
);

    logic [WIDTH-1:0] r_reg;
    logic             r_sout;
    logic [2:0]       r_op;

    logic             w_busy;
    logic             w_start_shift;
    logic             w_accept;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_next;
    logic             w_next_sout;

    assign w_start_shift = start && is_shift_op(op);
    assign w_accept      = !w_busy && w_start_shift;

    shreg_burst_ctl #(
        .CNT_W   (CNT_W)
    ) u_burst_ctl (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start_shift && !w_busy),
        .i_count (count),
        .o_busy  (w_busy),
        .o_done  (done)
    );

    // The accepting edge only latches the burst, so the register holds.
    always_comb begin
        if (w_busy) begin
            w_op = r_op;
        end else if (w_accept) begin
            w_op = OP_HOLD;
        end else begin
            w_op = op;
        end
    end

    always_comb begin
        w_next      = r_reg;
        w_next_sout = r_sout;
        case (w_op)
            OP_LOAD: w_next = load_data;
            OP_SHR: begin
                w_next      = {din, r_reg[WIDTH-1:1]};
                w_next_sout = r_reg[0];
            end
            OP_SAR: begin
                w_next      = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
                w_next_sout = r_reg[0];
            end
            OP_SHL: begin
                w_next      = {r_reg[WIDTH-2:0], din};
                w_next_sout = r_reg[WIDTH-1];
            end
            OP_ROR: begin
                w_next      = {r_reg[0], r_reg[WIDTH-1:1]};
                w_next_sout = r_reg[0];
            end
            OP_ROL: begin
                w_next      = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
                w_next_sout = r_reg[WIDTH-1];
            end
            default: begin
                w_next      = r_reg;
                w_next_sout = r_sout;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg  <= '0;
            r_sout <= 1'b0;
            r_op   <= OP_HOLD;
        end else begin
            r_reg  <= w_next;
            r_sout <= w_next_sout;
            if (w_accept) begin
                r_op <= op;
            end
        end
    end

    assign busy = w_busy;
    assign dout = r_reg;
    assign sout = r_sout;

endmodule
`default_nettype wire

// File: tb/tb_univ_shiftreg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_univ_shiftreg
//  Description : Scoreboard bench for univ_shiftreg with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shiftreg;

    localparam int W = 17;
    localparam int C = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] load_data = '0;
    logic         din = 1'b0;
    logic         start = 1'b0;
    logic [C-1:0] count = '0;
    logic         busy, done, sout;
    logic [W-1:0] dout;

    univ_shiftreg #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .op(op), .load_data(load_data), .din(din),
        .start(start), .count(count), .busy(busy), .done(done),
        .dout(dout), .sout(sout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dout;
        logic         sout;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] m_reg = '0;
    logic         m_sout = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_cnt = 0;
    logic [2:0]   m_op = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] o, input logic [W-1:0] ld, input logic d);
        case (o)
            3'd1: m_reg = ld;
            3'd2: begin m_sout = m_reg[0];   m_reg = {d, m_reg[W-1:1]}; end
            3'd3: begin m_sout = m_reg[0];   m_reg = {m_reg[W-1], m_reg[W-1:1]}; end
            3'd4: begin m_sout = m_reg[W-1]; m_reg = {m_reg[W-2:0], d}; end
            3'd5: begin m_sout = m_reg[0];   m_reg = {m_reg[0], m_reg[W-1:1]}; end
            3'd6: begin m_sout = m_reg[W-1]; m_reg = {m_reg[W-2:0], m_reg[W-1]}; end
            default: ;
        endcase
    endtask

    task automatic step(input logic [2:0] o, input logic [W-1:0] ld, input logic d,
                        input logic s, input logic [C-1:0] c);
        exp_t e;
        op = o; load_data = ld; din = d; start = s; count = c;
        if (m_busy) begin
            apply(m_op, ld, d);
            m_cnt--;
            m_done = (m_cnt == 0);
            m_busy = (m_cnt != 0);
        end else if (s && o >= 3'd2 && o <= 3'd6) begin
            if (c == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_cnt  = int'(c);
                m_op   = o;
                m_done = 1'b0;
            end
        end else begin
            apply(o, ld, d);
            m_done = 1'b0;
        end
        e.dout = m_reg; e.sout = m_sout; e.busy = m_busy; e.done = m_done;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("dout", 32'(dout), 32'(e.dout));
        check("sout", 32'(sout), 32'(e.sout));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(3'd0, W'($urandom), 1'($urandom), 1'b0, '0);
    endtask

    initial begin
        int bc;
        #3;
        check("rst_dout", 32'(dout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sout", 32'(sout), 0);
        rst = 1'b0;

        // single-step rotates
        step(3'd1, 17'h00001, 1'b0, 1'b0, '0);
        step(3'd5, '0, 1'b0, 1'b0, '0);
        check("ror_dout", 32'(dout), 32'h10000);
        check("ror_sout", 32'(sout), 1);
        step(3'd6, '0, 1'b0, 1'b0, '0);
        check("rol_dout", 32'(dout), 32'h00001);
        check("rol_sout", 32'(sout), 1);

        // arithmetic burst; inputs during the burst (incl. start) must be ignored
        step(3'd1, 17'h10000, 1'b0, 1'b0, '0);
        step(3'd3, '0, 1'b0, 1'b1, 5'd16);
        bc = int'(busy);
        for (int i = 0; i < 16; i++) begin
            step(3'd1, 17'h0abcd, 1'b1, 1'b1, 5'd3);
            bc += int'(busy);
        end
        check("sar_busy_cycles", 32'(bc), 16);
        check("sar_done", 32'(done), 1);
        check("sar_dout", 32'(dout), 32'h1FFFF);

        // serial fill
        step(3'd1, '0, 1'b0, 1'b0, '0);
        step(3'd4, '0, 1'b0, 1'b1, 5'd3);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        step(3'd0, '0, 1'b0, 1'b0, '0);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        check("fill_dout", 32'(dout), 32'h00005);
        check("fill_sout", 32'(sout), 0);
        check("fill_done", 32'(done), 1);

        // count=0 start, then start with LOAD
        step(3'd2, '0, 1'b1, 1'b1, 5'd0);
        check("cnt0_done", 32'(done), 1);
        check("cnt0_busy", 32'(busy), 0);
        step(3'd1, 17'h1234, 1'b0, 1'b1, 5'd4);
        check("ldstart_done", 32'(done), 0);
        check("ldstart_dout", 32'(dout), 32'h1234);
        hold(2);

        // back-to-back bursts
        step(3'd2, '0, 1'b0, 1'b1, 5'd2);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        step(3'd0, '0, 1'b0, 1'b0, '0);
        check("b2b_first_done", 32'(done), 1);
        step(3'd2, '0, 1'b1, 1'b1, 5'd2);
        check("b2b_busy", 32'(busy), 1);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        check("b2b_second_done", 32'(done), 1);

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), C'($urandom_range(0, 6)));
        end
        hold(8);

        // reset mid-burst after 4 shifts
        step(3'd1, 17'h1ACE5, 1'b0, 1'b0, '0);
        step(3'd2, '0, 1'b1, 1'b1, 5'd10);
        for (int i = 0; i < 4; i++) step(3'd0, '0, 1'b1, 1'b0, '0);
        check("pre_rst_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_dout", 32'(dout), 0);
        m_reg = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        op = 3'd2; start = 1'b1; count = 5'd3;
        @(posedge clk);
        #1;
        check("rst_held_busy", 32'(busy), 0);
        rst = 1'b0;
        hold(12);
        step(3'd4, '0, 1'b1, 1'b1, 5'd1);
        check("post_rst_accept", 32'(busy), 1);
        step(3'd0, '0, 1'b1, 1'b0, '0);
        check("post_rst_done", 32'(done), 1);
        hold(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
